// File: rtl/mem_access_unit.sv
// Data-memory access stage: one load/store per request over a req/ack bus.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_is_load,
  input  logic        mem_is_store,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic        mem_done,
  output logic        mem_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [31:0] rdata_word,
  output logic [1:0]  byte_off,
  output logic [2:0]  load_sel,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] TMAX =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wd_q;
  logic [31:0]       rdata_q;
  logic [1:0]        off_q;
  logic [2:0]        sel_q;
  logic              accept;
  logic              f3_bad;
  logic              mis_chk;
  logic              skip;
  logic              timeout;
  logic              is_sb;
  logic              is_sh;
  logic [3:0]        be_nx;
  logic [31:0]       wd_nx;

  assign accept = (state == IDLE) && mem_valid
                && (mem_is_load || mem_is_store);

  assign f3_bad = mem_is_load
    ? ((mem_funct3[1:0] == 2'b11) || (mem_funct3 == 3'd6))
    : (mem_funct3[2] || (mem_funct3[1:0] == 2'b11));

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_chk = !f3_bad && (
    ((mem_funct3[1:0] == 2'b01) && mem_addr[0]) ||
    ((mem_funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)));
  assign misalign = (state == DONE) && mis_q;
`else
  assign mis_chk = 1'b0;
`endif

  assign skip = f3_bad || mis_chk;

  assign timeout = (TIMEOUT_CYCLES != 0)
                 && (cnt == TMAX) && !bus_ack;

  assign is_sb = mem_is_store && (mem_funct3[1:0] == 2'b00);
  assign is_sh = mem_is_store && (mem_funct3[1:0] == 2'b01);

  // Place store data on the byte lanes selected by size and offset.
  always_comb begin
    be_nx = 4'b1111;
    wd_nx = mem_wdata;
    unique case (1'b1)
      is_sb: begin
        be_nx = 4'b0001 << mem_addr[1:0];
        wd_nx = {4{mem_wdata[7:0]}};
      end
      is_sh: begin
        be_nx = mem_addr[1] ? 4'b1100 : 4'b0011;
        wd_nx = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Next-state and pipeline stall.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          state_nx = skip ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack || timeout) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latches, timeout counter and captured read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      sel_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else if (accept) begin
      cnt     <= '0;
      err_q   <= skip;
      we_q    <= mem_is_store;
      addr_q  <= {mem_addr[31:2], 2'b00};
      be_q    <= be_nx;
      wd_q    <= wd_nx;
      off_q   <= mem_addr[1:0];
      sel_q   <= mem_funct3;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_chk;
`endif
    end else if (state == REQ) begin
      if (bus_ack) begin
        if (!we_q) rdata_q <= bus_rdata;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus_req    = (state == REQ);
  assign mem_done   = (state == DONE);
  assign mem_err    = (state == DONE) && err_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wd_q;
  assign rdata_word = rdata_q;
  assign byte_off   = off_q;
  assign load_sel   = sel_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction model with per-cycle compare,
// randomized loads/stores, directed boundary cases, timeout instance.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall, done, err;
  logic [31:0] rword;
  logic [1:0]  off;
  logic [2:0]  sel;
  logic        breq, bwe;
  logic [31:0] baddr, bwd;
  logic [3:0]  bbe;
`ifdef MISALIGN_TRAP_EN
  logic        mis;
  logic        t_mis;
`endif

  logic        t_valid = 1'b0;
  logic        t_ack = 1'b0;
  logic        t_stall, t_done, t_err;
  logic [31:0] t_rword;
  logic [1:0]  t_off;
  logic [2:0]  t_sel;
  logic        t_breq, t_bwe;
  logic [31:0] t_baddr, t_bwd;
  logic [3:0]  t_bbe;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(valid),
    .mem_is_load(is_load), .mem_is_store(is_store),
    .mem_funct3(funct3), .mem_addr(addr), .mem_wdata(wdata),
    .stall(stall), .mem_done(done), .mem_err(err),
`ifdef MISALIGN_TRAP_EN
    .misalign(mis),
`endif
    .rdata_word(rword), .byte_off(off), .load_sel(sel),
    .bus_req(breq), .bus_we(bwe), .bus_addr(baddr),
    .bus_be(bbe), .bus_wdata(bwd), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_to (
    .clk(clk), .rst_n(rst_n), .mem_valid(t_valid),
    .mem_is_load(1'b1), .mem_is_store(1'b0),
    .mem_funct3(3'd2), .mem_addr(32'h0000_5000),
    .mem_wdata(32'h0),
    .stall(t_stall), .mem_done(t_done), .mem_err(t_err),
`ifdef MISALIGN_TRAP_EN
    .misalign(t_mis),
`endif
    .rdata_word(t_rword), .byte_off(t_off), .load_sel(t_sel),
    .bus_req(t_breq), .bus_we(t_bwe), .bus_addr(t_baddr),
    .bus_be(t_bbe), .bus_wdata(t_bwd), .bus_ack(t_ack),
    .bus_rdata(32'h5A5A_5A5A)
  );

  int total = 0;
  int bad = 0;

  task automatic chk32(input string n, input logic [31:0] a,
                       input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask

  localparam int P_IDLE = 0;
  localparam int P_ACC  = 1;
  localparam int P_REQ  = 2;
  localparam int P_DONE = 3;
  localparam int P_RST  = 4;

  int          phase = P_RST;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wd = '0;
  logic [3:0]  e_be = '0;
  logic        e_we = 1'b0;
  logic        e_err = 1'b0;
  logic        e_mis = 1'b0;
  logic [31:0] m_rword = '0;
  logic [1:0]  m_off = '0;
  logic [2:0]  m_sel = '0;
  int          stall_cycles = 0;
  int          req_cycles = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wd = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;
  logic        cap_err = 1'b0;
  logic        cap_mis = 1'b0;

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    chk1("stall", stall, phase == P_ACC || phase == P_REQ);
    chk1("bus_req", breq, phase == P_REQ);
    chk1("mem_done", done, phase == P_DONE);
    chk1("mem_err", err, phase == P_DONE && e_err);
`ifdef MISALIGN_TRAP_EN
    chk1("misalign", mis, phase == P_DONE && e_mis);
`endif
    if (phase != P_REQ) begin
      chk32("rdata_word", rword, m_rword);
      chk32("byte_off", 32'(off), 32'(m_off));
      chk32("load_sel", 32'(sel), 32'(m_sel));
    end
    if (phase == P_REQ) begin
      chk32("bus_addr", baddr, e_addr);
      chk32("bus_be", 32'(bbe), 32'(e_be));
      chk1("bus_we", bwe, e_we);
      if (e_we) chk32("bus_wdata", bwd, e_wd);
      cap_addr = baddr;
      cap_be   = bbe;
      cap_wd   = bwd;
      cap_we   = bwe;
    end
    if (phase == P_DONE) begin
      cap_err = err;
`ifdef MISALIGN_TRAP_EN
      cap_mis = mis;
`else
      cap_mis = 1'b0;
`endif
    end
    if (stall) stall_cycles++;
    if (breq) req_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic ld, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int dly, input logic [31:0] rd);
    logic legal;
    logic mb;
    int   sz;
    int   lane;
    legal = ld ? (f != 3'd3 && f != 3'd6 && f != 3'd7) : (f < 3'd3);
    sz = 1 << f[1:0];
    mb = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mb = legal && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
`endif
    e_addr = a & 32'hFFFF_FFFC;
    e_we   = !ld;
    e_err  = !legal || mb;
    e_mis  = mb;
    e_be   = 4'hF;
    e_wd   = wd;
    if (!ld && legal) begin
      lane = int'(a[1:0]) & ~(sz - 1);
      e_be = 4'(((1 << sz) - 1) << lane);
      for (int i = 0; i < 4; i++)
        e_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    valid = 1'b1; is_load = ld; is_store = !ld;
    funct3 = f; addr = a; wdata = wd;
    bus_ack = 1'($urandom_range(1, 0));
    stall_cycles = 0; req_cycles = 0;
    phase = P_ACC;
    tick();
    valid = 1'b0;
    funct3 = 3'($urandom_range(7, 0));
    addr = $urandom; wdata = $urandom;
    if (!e_err) begin
      for (int k = 0; k <= dly; k++) begin
        phase = P_REQ;
        valid = 1'($urandom_range(1, 0));
        bus_ack = (k == dly);
        bus_rdata = (k == dly) ? rd : $urandom;
        tick();
      end
      if (ld) m_rword = rd;
    end
    phase = P_DONE;
    m_off = a[1:0];
    m_sel = f;
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2;
    bus_ack = 1'($urandom_range(1, 0));
    bus_rdata = $urandom;
    tick();
    valid = 1'b0; bus_ack = 1'b0;
    phase = P_IDLE;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      phase = P_IDLE;
      valid = 1'($urandom_range(1, 0));
      is_load = 1'b0; is_store = 1'b0;
      bus_ack = 1'($urandom_range(1, 0));
      tick();
    end
    valid = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic t_op(input int ack_at, output int nreq,
                      output logic d_err, output logic [31:0] d_rd,
                      output logic seen);
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    nreq = 0; seen = 1'b0; d_err = 1'b0; d_rd = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      t_ack = (c == ack_at);
      @(negedge clk);
      if (t_breq) nreq++;
      if (t_done) begin
        seen = 1'b1; d_err = t_err; d_rd = t_rword;
      end
      tick();
    end
    t_ack = 1'b0;
  endtask

  initial begin
    int          nreq;
    logic        derr;
    logic        seen;
    logic [31:0] drd;
    logic        ld;
    logic [2:0]  f;

    tick();
    @(negedge clk);
    chk32("reset_bus_addr", baddr, 32'h0);
    chk32("reset_bus_be", 32'(bbe), 32'h0);
    chk1("reset_bus_we", bwe, 1'b0);
    #1;
    rst_n = 1'b1;
    phase = P_IDLE;
    tick();

    run_op(1'b1, 3'd2, 32'h1000_0008, 32'h0, 0, 32'hDEAD_BEEF);
    chk32("lw_addr", cap_addr, 32'h1000_0008);
    chk32("lw_be", 32'(cap_be), 32'hF);
    chk32("lw_rdata", rword, 32'hDEAD_BEEF);
    chk32("lw_off", 32'(off), 32'd0);
    chk32("lw_sel", 32'(sel), 32'd2);
    chk32("lw_stall_cycles", stall_cycles, 2);
    idle(1);

    run_op(1'b0, 3'd0, 32'h0000_2003, 32'h0000_00A5, 1, 32'h0);
    chk32("sb_be", 32'(cap_be), 32'h8);
    chk32("sb_wdata", cap_wd, 32'hA5A5_A5A5);
    chk1("sb_we", cap_we, 1'b1);
    chk32("sb_addr", cap_addr, 32'h0000_2000);
    run_op(1'b0, 3'd1, 32'h0000_2002, 32'h0000_1234, 0, 32'h0);
    chk32("sh_be", 32'(cap_be), 32'hC);
    chk32("sh_wdata", cap_wd, 32'h1234_1234);

    run_op(1'b1, 3'd4, 32'h0000_3001, 32'h0, 5, 32'h0000_7700);
    chk32("lbu_req_cycles", req_cycles, 6);
    chk32("lbu_stall_cycles", stall_cycles, 7);
    chk32("lbu_off", 32'(off), 32'd1);
    chk32("lbu_sel", 32'(sel), 32'd4);

    run_op(1'b1, 3'd3, 32'h0000_3000, 32'h0, 0, 32'h0);
    chk32("illegal_req_cycles", req_cycles, 0);
    chk1("illegal_err", cap_err, 1'b1);

    run_op(1'b1, 3'd2, 32'h0000_4002, 32'h0, 1, 32'h0BAD_F00D);
`ifdef MISALIGN_TRAP_EN
    chk32("mis_req_cycles", req_cycles, 0);
    chk1("mis_err", cap_err, 1'b1);
    chk1("mis_flag", cap_mis, 1'b1);
`else
    chk32("mis_off_req_cycles", req_cycles, 2);
    chk32("mis_off_rdata", rword, 32'h0BAD_F00D);
    chk32("mis_off_be", 32'(cap_be), 32'hF);
`endif

    valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
    funct3 = 3'd2; addr = 32'h6000_0004;
    e_addr = 32'h6000_0004; e_be = 4'hF; e_we = 1'b0;
    e_err = 1'b0; e_mis = 1'b0;
    phase = P_ACC;
    tick();
    valid = 1'b0; bus_ack = 1'b0; phase = P_REQ;
    tick();
    rst_n = 1'b0;
    phase = P_RST;
    m_rword = '0; m_off = '0; m_sel = '0;
    @(negedge clk);
    chk1("rst_req_drop", breq, 1'b0);
    chk1("rst_no_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    phase = P_IDLE;
    tick();
    run_op(1'b1, 3'd2, 32'h0000_0100, 32'h0, 2, 32'hC0FF_EE00);
    chk32("post_rst_rdata", rword, 32'hC0FF_EE00);

    for (int n = 0; n < 300; n++) begin
      ld = 1'($urandom_range(1, 0));
      f = 3'($urandom_range(7, 0));
      if ($urandom_range(3, 0) != 0)
        f = ld ? {1'($urandom_range(1, 0)), 2'($urandom_range(2, 0))}
               : 3'($urandom_range(2, 0));
      run_op(ld, f, $urandom, $urandom, int'($urandom_range(5, 0)),
             $urandom);
      idle(int'($urandom_range(2, 0)));
    end

    t_op(1, nreq, derr, drd, seen);
    chk1("to_warm_seen", seen, 1'b1);
    chk32("to_warm_req", nreq, 2);
    chk1("to_warm_err", derr, 1'b0);
    chk32("to_warm_rdata", drd, 32'h5A5A_5A5A);
    t_op(-1, nreq, derr, drd, seen);
    chk1("to_seen", seen, 1'b1);
    chk32("to_req_cycles", nreq, 4);
    chk1("to_err", derr, 1'b1);
    chk32("to_rdata", drd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage that sits directly upstream of the load extender.
- Takes one load or store per request from the execute stage, drives a single-outstanding req/ack data bus with word-aligned address and byte enables, and captures the returned word.
- For loads, presents the captured word, byte offset and funct3 to the load extender.
- Stalls the pipeline for the whole bus transaction.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for bus_ack before aborting with error; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  execute stage presents an operation this cycle
- mem_is_load  in  1  operation is a load
- mem_is_store  in  1  operation is a store; never set together with mem_is_load
- mem_funct3  in  3  RV32 funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU)
- mem_addr  in  32  effective byte address (ALU result)
- mem_wdata  in  32  store source register value
- stall  out  1  hold the pipeline
- mem_done  out  1  one-cycle completion pulse
- mem_err  out  1  valid with mem_done; transaction aborted
- rdata_word  out  32  captured raw bus word, to the load extender read_data
- byte_off  out  2  latched mem_addr[1:0], to the load extender offset input
- load_sel  out  3  latched funct3, to the load extender select input
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  slave completion; bus_rdata valid this cycle for reads
- bus_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs, the timeout counter and all latched registers are 0. Reset during REQ drops bus_req immediately; the transaction is abandoned with no done pulse.
- FSM states are IDLE, REQ and DONE.
- IDLE:
  - When mem_valid and (is_load or is_store): latch addr, funct3, we and lane-formatted wdata/be; go to REQ.
  - stall is combinationally 1 in this cycle.
  - Otherwise remain in IDLE with stall=0.
- Illegal funct3 (load 3/6/7, store ≥3): no bus cycle; go directly to DONE with mem_err=1.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_be and bus_wdata are driven from registers and held stable until ack. stall=1.
  - On bus_ack: latch bus_rdata into rdata_word (loads only; stores leave it unchanged), drop bus_req, go to DONE.
  - An ack in the first REQ cycle is legal, giving minimum load latency IDLE→REQ→DONE (3 cycles including request).
  - The counter increments each REQ cycle without ack. When counter==TIMEOUT_CYCLES-1 and no ack: drop bus_req, rdata_word=0, go to DONE with mem_err=1.
- DONE: mem_done=1 and stall=0 for one cycle; rdata_word, byte_off and load_sel hold until the next accepted operation; go to IDLE. mem_valid in DONE is ignored and accepted the following cycle.
- bus_ack outside REQ is ignored.
- Store formatting:
  - SB: be=4'b0001<<off, wdata={4{wdata[7:0]}}.
  - SH: be=off[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
- Loads drive be=4'b1111.
- Misaligned half/word with the macro off: the bus address is still word-aligned; the extender's lane selection applies.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, performs no bus cycle.
  - Goes IDLE→DONE with mem_err=1.
  - Adds output misalign (1 bit), which pulses with mem_done and is 0 on other errors.
- Undefined: no check, no misalign port, and misaligned accesses proceed as described in Behaviour.

Test Plan:
- LW addr=0x1000_0008, ack on first REQ cycle with rdata=0xDEAD_BEEF -> bus_addr=0x1000_0008, be=1111; mem_done on cycle 3 with rdata_word=0xDEAD_BEEF, byte_off=0, load_sel=2; stall high for 2 cycles.
- SB addr=0x2003, wdata=0x0000_00A5 -> be=1000, bus_wdata=0xA5A5_A5A5, bus_we=1, bus_addr=0x2000; SH addr=0x2002, wdata=0x1234 -> be=1100, bus_wdata=0x1234_1234.
- LBU addr=0x3001, ack delayed 5 cycles -> bus_req high 6 cycles with stable address; byte_off=1, load_sel=4; stall released only in DONE.
- TIMEOUT_CYCLES=4, no ack -> bus_req high exactly 4 cycles, then mem_done=1, mem_err=1, rdata_word=0.
- rst_n pulled low in the second REQ cycle -> bus_req=0 immediately and no mem_done; after release, a new LW completes normally.
- MISALIGN_TRAP_EN: LW addr=0x4002 -> no bus_req; mem_done, mem_err and misalign all =1 on the cycle after acceptance.
